// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer for the accumulator CPU. Fetches one
//   32-bit word at a time from the instruction port, decodes
//   opcode[31:29] / source[28:27] / dest[26:25] / immediate[24:0], and drives
//   the data-memory, register-file and ALU ports until a HALT is decoded.
//   Register 2'b10 is the accumulator.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   start                  level; launches execution from IDLE
//   Read_PC / Instruction  instruction address / word (combinational read)
//   Op2En, Op2RW           data-memory strobe, 0 = read, 1 = write
//   M_Clear                one-cycle clear strobe for the word at R_W_Addr
//   R_W_Addr, DataWrite    data-memory address / write data
//   DataRead               data-memory read data (combinational)
//   opwrite, reg_write     register write strobe / index
//   data                   register write data
//   src_1, src_2           register read indices
//   data_src_1/2           register read data (combinational)
//   rs, rt, op, rd         ALU operands, ALU opcode, ALU result
//   busy, halted           status: executing / parked in HALT
//   instr_count            retired-instruction counter, wraps
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_FETCH  | capture Instruction into IR
//   S_DECODE | dispatch on opcode
//   S_OPRD   | read source register into A
//   S_EXEC   | present A and immediate to the ALU, capture result into R
//   S_MEMRD  | data-memory read strobe, capture DataRead into R
//   S_MEMWR  | data-memory write strobe of A
//   S_CLR    | data-memory clear strobe
//   S_WB     | register write of R
//   S_HALT   | parked until reset
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [31:0] START_PC = 32'd0,
    parameter int          DATA_W   = 32,
    parameter int          IMM_W    = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [31:0]       Read_PC,
    input  logic [31:0]       Instruction,
    output logic              Op2En,
    output logic              Op2RW,
    output logic              M_Clear,
    output logic [31:0]       R_W_Addr,
    output logic [DATA_W-1:0] DataWrite,
    input  logic [DATA_W-1:0] DataRead,
    output logic              opwrite,
    output logic [1:0]        reg_write,
    output logic [1:0]        src_1,
    output logic [1:0]        src_2,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] data_src_1,
    input  logic [DATA_W-1:0] data_src_2,
    output logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] rt,
    output logic [3:0]        op,
    input  logic [DATA_W-1:0] rd,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPRD,
        S_EXEC,
        S_MEMRD,
        S_MEMWR,
        S_CLR,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_DIV  = 3'b010;
    localparam logic [2:0] OPC_MUL  = 3'b011;
    localparam logic [2:0] OPC_CLR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b101;
    localparam logic [2:0] OPC_LD   = 3'b110;
    localparam logic [2:0] OPC_ST   = 3'b111;

    localparam logic [1:0] ACC_IDX = 2'b10;

    state_t state, state_nx;

    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] r_q;
    logic [31:0]       pc_q;
    logic [15:0]       count_q;

    // Last driven value of every non-strobe output; outputs fall back to
    // these whenever the current state does not drive them.
    logic              op2rw_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] dwr_q;
    logic [1:0]        reg_write_q;
    logic [1:0]        src_1_q;
    logic [1:0]        src_2_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [3:0]        op_q;

    logic [2:0]        opc;
    logic [1:0]        fonte_a;
    logic [1:0]        dest;
    logic [DATA_W-1:0] imm_data;
    logic [31:0]       imm_addr;
    logic [3:0]        alu_code;

    logic              retire;
    logic              halt_retire;

    assign opc      = ir[31:29];
    assign fonte_a  = ir[28:27];
    assign dest     = ir[26:25];
    assign imm_data = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    assign imm_addr = {{(32-IMM_W){1'b0}}, ir[IMM_W-1:0]};

    always_comb begin
        alu_code = 4'b0000;
        case (opc)
            OPC_ADD: alu_code = 4'b1000;
            OPC_SUB: alu_code = 4'b0100;
            OPC_DIV: alu_code = 4'b0001;
            OPC_MUL: alu_code = 4'b0010;
            default: alu_code = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nx    = state;
        retire      = 1'b0;
        halt_retire = 1'b0;

        Op2En       = 1'b0;
        M_Clear     = 1'b0;
        opwrite     = 1'b0;
        Op2RW       = op2rw_q;
        R_W_Addr    = addr_q;
        DataWrite   = dwr_q;
        reg_write   = reg_write_q;
        src_1       = src_1_q;
        src_2       = src_2_q;
        data        = data_q;
        rs          = rs_q;
        rt          = rt_q;
        op          = op_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (opc)
                    OPC_LD:   state_nx = S_MEMRD;
                    OPC_CLR:  state_nx = S_CLR;
                    OPC_HALT: begin
                        state_nx    = S_HALT;
                        halt_retire = 1'b1;
                    end
                    default:  state_nx = S_OPRD;
                endcase
            end
            S_OPRD: begin
                if (opc == OPC_ST) begin
                    src_1    = fonte_a;
                    state_nx = S_MEMWR;
                end else begin
                    src_2    = fonte_a;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                rs       = a_q;
                rt       = imm_data;
                op       = alu_code;
                state_nx = S_WB;
            end
            S_MEMRD: begin
                Op2En    = 1'b1;
                Op2RW    = 1'b0;
                R_W_Addr = imm_addr;
                state_nx = S_WB;
            end
            S_MEMWR: begin
                Op2En     = 1'b1;
                Op2RW     = 1'b1;
                R_W_Addr  = imm_addr;
                DataWrite = a_q;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_CLR: begin
                M_Clear  = 1'b1;
                R_W_Addr = imm_addr;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_WB: begin
                opwrite   = 1'b1;
                reg_write = (opc == OPC_LD) ? dest : ACC_IDX;
                data      = r_q;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath registers, PC and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir          <= '0;
            a_q         <= '0;
            r_q         <= '0;
            pc_q        <= START_PC;
            count_q     <= '0;
            op2rw_q     <= 1'b0;
            addr_q      <= '0;
            dwr_q       <= '0;
            reg_write_q <= '0;
            src_1_q     <= '0;
            src_2_q     <= '0;
            data_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            op_q        <= '0;
        end else begin
            op2rw_q     <= Op2RW;
            addr_q      <= R_W_Addr;
            dwr_q       <= DataWrite;
            reg_write_q <= reg_write;
            src_1_q     <= src_1;
            src_2_q     <= src_2;
            data_q      <= data;
            rs_q        <= rs;
            rt_q        <= rt;
            op_q        <= op;

            case (state)
                S_FETCH: ir  <= Instruction;
                S_OPRD:  a_q <= (opc == OPC_ST) ? data_src_1 : data_src_2;
                S_EXEC:  r_q <= rd;
                S_MEMRD: r_q <= DataRead;
                default: ;
            endcase

            // HALT retires the instruction but leaves the PC on it.
            if (retire) begin
                pc_q    <= pc_q + 32'd1;
                count_q <= count_q + 16'd1;
            end else if (halt_retire) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign Read_PC     = pc_q;
    assign instr_count = count_q;
    assign busy        = (state != S_IDLE) && (state != S_HALT);
    assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with instruction memory, data memory,
// register file and ALU models. A second instance with START_PC at the top
// of the address space exercises PC wrap.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] Read_PC, Instruction, R_W_Addr, DataWrite, DataRead, data;
    logic [31:0] data_src_1, data_src_2, rs, rt, rd;
    logic        Op2En, Op2RW, M_Clear, opwrite, busy, halted;
    logic [1:0]  reg_write, src_1, src_2;
    logic [3:0]  op;
    logic [15:0] instr_count;

    logic        start2;
    logic [31:0] pc2, instr2, addr2, dwr2, data2, rs2, rt2;
    logic        op2en2, op2rw2, clr2, opw2, busy2, halted2;
    logic [1:0]  rw2, s1_2, s2_2;
    logic [3:0]  op_2;
    logic [15:0] cnt2;

    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    logic [31:0] rf   [4];

    logic        tb_mem_we = 1'b0;
    logic [3:0]  tb_mem_idx = '0;
    logic [31:0] tb_mem_val = '0;
    logic        tb_rf_we = 1'b0;
    logic [1:0]  tb_rf_idx = '0;
    logic [31:0] tb_rf_val = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_opw, m_en, m_clr, m_halt, m_busy;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Read_PC(Read_PC), .Instruction(Instruction),
        .Op2En(Op2En), .Op2RW(Op2RW), .M_Clear(M_Clear),
        .R_W_Addr(R_W_Addr), .DataWrite(DataWrite), .DataRead(DataRead),
        .opwrite(opwrite), .reg_write(reg_write), .src_1(src_1), .src_2(src_2),
        .data(data), .data_src_1(data_src_1), .data_src_2(data_src_2),
        .rs(rs), .rt(rt), .op(op), .rd(rd),
        .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    instr_sequencer #(.START_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .Read_PC(pc2), .Instruction(instr2),
        .Op2En(op2en2), .Op2RW(op2rw2), .M_Clear(clr2),
        .R_W_Addr(addr2), .DataWrite(dwr2), .DataRead(32'd7),
        .opwrite(opw2), .reg_write(rw2), .src_1(s1_2), .src_2(s2_2),
        .data(data2), .data_src_1(32'd0), .data_src_2(32'd0),
        .rs(rs2), .rt(rt2), .op(op_2), .rd(32'd0),
        .busy(busy2), .halted(halted2), .instr_count(cnt2)
    );

    // Wrap instance: mem read at 0xFFFFFFFF, halt everywhere else.
    assign instr2 = (pc2 == 32'hFFFF_FFFF) ? 32'hC000_0008 : 32'hA000_0000;

    assign Instruction = imem[Read_PC[3:0]];
    assign DataRead    = dmem[R_W_Addr[3:0]];
    assign data_src_1  = rf[src_1];
    assign data_src_2  = rf[src_2];

    always_comb begin
        rd = 32'd0;
        case (op)
            4'b1000: rd = rs + rt;
            4'b0100: rd = rs - rt;
            4'b0010: rd = rs * rt;
            4'b0001: rd = (rt == 32'd0) ? 32'd0 : rs / rt;
            default: rd = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (tb_mem_we)
            dmem[tb_mem_idx] <= tb_mem_val;
        else if (M_Clear)
            dmem[R_W_Addr[3:0]] <= 32'd0;
        else if (Op2En && Op2RW)
            dmem[R_W_Addr[3:0]] <= DataWrite;
    end

    always @(posedge clk) begin
        if (tb_rf_we)
            rf[tb_rf_idx] <= tb_rf_val;
        else if (opwrite)
            rf[reg_write] <= data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 start = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic poke_mem(input logic [3:0] idx, input logic [31:0] val);
        tb_mem_we = 1'b1; tb_mem_idx = idx; tb_mem_val = val;
        @(posedge clk);
        #1 tb_mem_we = 1'b0;
    endtask

    task automatic poke_rf(input logic [1:0] idx, input logic [31:0] val);
        tb_rf_we = 1'b1; tb_rf_idx = idx; tb_rf_val = val;
        @(posedge clk);
        #1 tb_rf_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 32'hA000_0000;

        // ---- reset state
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", Read_PC, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_halted", halted, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_strobes", {Op2En, M_Clear, opwrite, Op2RW}, 32'd0);
        chk("rst_addr", R_W_Addr, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_alu", {rs[7:0], rt[7:0], op}, 32'd0);
        chk("rst_pc_wrap", pc2, 32'hFFFF_FFFF);
        #1 rst_n = 1'b1;

        // ---- program: load, add, store, halt
        for (int i = 0; i < 4; i++) poke_rf(i[1:0], 32'd0);
        poke_mem(4'd8, 32'd30);
        poke_mem(4'd9, 32'd0);
        imem[0] = 32'hC000_0008;
        imem[1] = 32'h0000_0005;
        imem[2] = 32'hF000_0009;
        imem[3] = 32'hA000_0000;
        m_opw = '0; m_en = '0; m_halt = '0; m_busy = '0;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            m_opw[c]  = opwrite;
            m_en[c]   = Op2En;
            m_halt[c] = halted;
            m_busy[c] = busy;
            if (c == 4) chk("ld_wb_data", {data[29:0], reg_write}, {30'd30, 2'b00});
            if (c == 13) chk("st_data", DataWrite, 32'd35);
            if (c == 13) chk("st_addr_rw", {R_W_Addr[30:0], Op2RW}, {31'd9, 1'b1});
        end
        chk("prog_opwrite_cycles", m_opw, 32'h0000_0210);
        chk("prog_op2en_cycles", m_en, 32'h0000_2008);
        chk("prog_halt_cycles", m_halt, 32'h001F_0000);
        chk("prog_busy_cycles", m_busy, 32'h0000_FFFE);
        chk("prog_r0", rf[0], 32'd30);
        chk("prog_acc", rf[2], 32'd35);
        chk("prog_mem9", dmem[9], 32'd35);
        chk("prog_count", instr_count, 32'd4);
        chk("prog_pc", Read_PC, 32'd3);
        chk("prog_addr_held", R_W_Addr, 32'd9);

        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("halt_ignores_start", {halted, busy, Read_PC[3:0], instr_count[3:0]},
            {1'b1, 1'b0, 4'd3, 4'd4});

        // ---- ALU ops with R0 = 12
        do_reset();
        poke_rf(2'd0, 32'd12);
        imem[0] = 32'h2000_0003;
        imem[1] = 32'h6000_0002;
        imem[2] = 32'h4000_0004;
        imem[3] = 32'hA000_0000;
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 4)  chk("sub_exec", {rs[7:0], rt[7:0], op}, {8'd12, 8'd3, 4'b0100});
            if (c == 5)  chk("sub_wb", {opwrite, reg_write}, {1'b1, 2'b10});
            if (c == 6)  chk("sub_acc", rf[2], 32'd9);
            if (c == 9)  chk("mul_exec", {rs[7:0], rt[7:0], op}, {8'd12, 8'd2, 4'b0010});
            if (c == 11) chk("mul_acc", rf[2], 32'd24);
            if (c == 14) chk("div_exec", {rs[7:0], rt[7:0], op}, {8'd12, 8'd4, 4'b0001});
            if (c == 16) chk("div_acc", rf[2], 32'd3);
        end
        chk("alu_halt", {halted, instr_count}, {1'b1, 16'd4});

        // ---- memory clear of word 9
        do_reset();
        imem[0] = 32'h8000_0009;
        imem[1] = 32'hA000_0000;
        m_clr = '0;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            m_clr[c] = M_Clear;
            if (c == 3) chk("clr_addr_en", {R_W_Addr[30:0], Op2En}, {31'd9, 1'b0});
        end
        chk("clr_cycles", m_clr, 32'h0000_0008);
        chk("clr_mem9", dmem[9], 32'd0);
        chk("clr_done", {halted, Read_PC[7:0], instr_count[7:0]}, {1'b1, 8'd1, 8'd2});

        // ---- reset in the EXEC cycle of an add
        do_reset();
        imem[0] = 32'h0000_0005;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        chk("abort_exec_seen", {rs[7:0], rt[7:0], op}, {8'd12, 8'd5, 4'b1000});
        rst_n = 1'b0;
        tick();
        chk("abort_idle", {busy, halted, opwrite, Op2En, M_Clear}, 32'd0);
        chk("abort_pc", Read_PC, 32'd0);
        chk("abort_outputs", {rs[7:0], rt[7:0], op, data[7:0], R_W_Addr[3:0]}, 32'd0);
        rst_n = 1'b1;
        m_opw = '0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            m_opw[c] = opwrite;
        end
        chk("abort_no_opwrite", m_opw, 32'd0);
        chk("abort_acc_kept", rf[2], 32'd3);
        chk("abort_count", instr_count, 32'd0);

        // ---- PC wrap from 0xFFFFFFFF
        do_reset();
        start2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 4) chk("wrap_wb", {opw2, data2[7:0], pc2[7:0]}, {1'b1, 8'd7, 8'hFF});
            if (c == 5) chk("wrap_pc", pc2, 32'd0);
        end
        chk("wrap_halt", {halted2, cnt2}, {1'b1, 16'd2});
        chk("wrap_pc_final", pc2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
